// File: rtl/image_dot_pkg.sv
`default_nettype none
// ============================================================================
// image_dot_pkg : shared constants for the image_dot dot-product stage
// Revision      : 1.0
// ============================================================================
package image_dot_pkg;

    // CFG_DOT register: shift amount in the low bits, ReLU enable above it
    localparam int CFG_DOT     = 6;
    localparam int SHIFT_WIDTH = 6;
    localparam int RELU_BIT    = 8;

endpackage
`default_nettype wire

// File: rtl/dot_tree.sv
`default_nettype none
// ============================================================================
// dot_tree : two-stage pipelined lane-wise signed multiply and adder tree
// Revision : 1.0
// ============================================================================
module dot_tree #(
    parameter int GROUP_NB  = 4,
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 16,
    parameter int ACC_WIDTH = 48
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              in_val,
    input  logic                              in_last,
    input  logic [GROUP_NB*IMG_WIDTH-1:0]     img_bus,
    input  logic [GROUP_NB*KER_WIDTH-1:0]     ker_bus,
    output logic                              sum_val,
    output logic                              sum_last,
    output logic signed [ACC_WIDTH-1:0]       sum
);

    localparam int PROD_WIDTH = IMG_WIDTH + KER_WIDTH;

    logic signed [PROD_WIDTH-1:0] prod_d [GROUP_NB];
    logic signed [PROD_WIDTH-1:0] prod_q [GROUP_NB];
    logic                         s1_val;
    logic                         s1_last;
    logic signed [ACC_WIDTH-1:0]  tree_sum;

    for (genvar i = 0; i < GROUP_NB; i++) begin : g_lane
        assign prod_d[i] = PROD_WIDTH'($signed(img_bus[i*IMG_WIDTH +: IMG_WIDTH]))
                         * PROD_WIDTH'($signed(ker_bus[i*KER_WIDTH +: KER_WIDTH]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_val  <= 1'b0;
            s1_last <= 1'b0;
            for (int i = 0; i < GROUP_NB; i++) prod_q[i] <= '0;
        end else if (en) begin
            s1_val  <= in_val;
            s1_last <= in_last;
            for (int i = 0; i < GROUP_NB; i++) prod_q[i] <= prod_d[i];
        end
    end

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < GROUP_NB; i++) tree_sum = tree_sum + ACC_WIDTH'(prod_q[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_val  <= 1'b0;
            sum_last <= 1'b0;
            sum      <= '0;
        end else if (en) begin
            sum_val  <= s1_val;
            sum_last <= s1_last;
            sum      <= tree_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/image_dot.sv
`default_nettype none
// ============================================================================
// image_dot : joins pixel and kernel streams, accumulates per-frame dot
//             products and emits one shifted, saturated, optionally ReLU'd result
// Revision  : 1.0
// ============================================================================
module image_dot
    import image_dot_pkg::*;
#(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int GROUP_NB   = 4,
    parameter int IMG_WIDTH  = 16,
    parameter int KER_WIDTH  = 16,
    parameter int ACC_WIDTH  = 48,
    parameter int RES_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
    input  logic                          image_last,
    input  logic                          image_val,
    output logic                          image_rdy,
    input  logic [GROUP_NB*KER_WIDTH-1:0] kernel_bus,
    input  logic                          kernel_val,
    output logic                          kernel_rdy,
    output logic [RES_WIDTH-1:0]          result_bus,
    output logic                          result_val,
    input  logic                          result_rdy
);

    localparam logic signed [ACC_WIDTH-1:0] RES_MAX =
        $signed({{(ACC_WIDTH-RES_WIDTH+1){1'b0}}, {(RES_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_WIDTH-1:0] RES_MIN = ~RES_MAX;

    logic                         en;
    logic [SHIFT_WIDTH-1:0]       shift;
    logic                         relu;
    logic                         sum_val;
    logic                         sum_last;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic                         first;
    logic                         s3_val;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic [RES_WIDTH-1:0]         res_d;
    logic                         unused_cfg;

    // Whole pipeline stalls only when a held result is not being taken
    assign en         = ~(result_val & ~result_rdy);
    assign image_rdy  = en & kernel_val;
    assign kernel_rdy = en & image_val;

    assign unused_cfg = ^{cfg_data[CFG_DWIDTH-1:RELU_BIT+1], cfg_data[RELU_BIT-1:SHIFT_WIDTH]};

    always_ff @(posedge clk) begin
        if (rst) begin
            shift <= '0;
            relu  <= 1'b0;
        end else if (cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_DOT))) begin
            shift <= cfg_data[SHIFT_WIDTH-1:0];
            relu  <= cfg_data[RELU_BIT];
        end
    end

    dot_tree #(
        .GROUP_NB  (GROUP_NB),
        .IMG_WIDTH (IMG_WIDTH),
        .KER_WIDTH (KER_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_tree (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_val   (image_val & kernel_val),
        .in_last  (image_last),
        .img_bus  (image_bus),
        .ker_bus  (kernel_bus),
        .sum_val  (sum_val),
        .sum_last (sum_last),
        .sum      (sum)
    );

    // acc holds the completed frame total in the cycle s3_val is high
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            first  <= 1'b1;
            s3_val <= 1'b0;
        end else if (en) begin
            s3_val <= sum_val & sum_last;
            if (sum_val) begin
                acc   <= first ? sum : acc + sum;
                first <= sum_last;
            end
        end
    end

    assign shifted = acc >>> shift;

    always_comb begin
        res_d = shifted[RES_WIDTH-1:0];
        if (shifted > RES_MAX)
            res_d = {1'b0, {(RES_WIDTH-1){1'b1}}};
        else if (shifted < RES_MIN)
            res_d = {1'b1, {(RES_WIDTH-1){1'b0}}};
        if (relu && res_d[RES_WIDTH-1])
            res_d = '0;
    end

    // With en high the held result is either absent or being accepted now
    always_ff @(posedge clk) begin
        if (rst) begin
            result_val <= 1'b0;
            result_bus <= '0;
        end else if (en) begin
            result_val <= s3_val;
            if (s3_val) result_bus <= res_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_image_dot.sv
`default_nettype none
// ============================================================================
// tb_image_dot : scoreboard bench for image_dot
// Revision     : 1.0
// ============================================================================
module tb_image_dot;
    import image_dot_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_data = '0;
    logic [4:0]  cfg_addr = '0;
    logic        cfg_valid = 1'b0;
    logic [63:0] image_bus = '0;
    logic        image_last = 1'b0;
    logic        image_val = 1'b0;
    logic        image_rdy;
    logic [63:0] kernel_bus = '0;
    logic        kernel_val = 1'b0;
    logic        kernel_rdy;
    logic [15:0] result_bus;
    logic        result_val;
    logic        result_rdy = 1'b1;

    int     total = 0;
    int     bad = 0;
    longint exp_q[$];
    longint m_acc = 0;
    bit     m_first = 1'b1;
    int     cur_shift = 0;
    bit     cur_relu = 1'b0;
    bit     tog = 1'b0;

    image_dot u_dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_data   (cfg_data),
        .cfg_addr   (cfg_addr),
        .cfg_valid  (cfg_valid),
        .image_bus  (image_bus),
        .image_last (image_last),
        .image_val  (image_val),
        .image_rdy  (image_rdy),
        .kernel_bus (kernel_bus),
        .kernel_val (kernel_val),
        .kernel_rdy (kernel_rdy),
        .result_bus (result_bus),
        .result_val (result_val),
        .result_rdy (result_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic longint model(input longint acc);
        longint v;
        v = acc >>> cur_shift;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        if (cur_relu && v < 0) v = 0;
        return v;
    endfunction

    function automatic void model_beat(input logic [63:0] p, input logic [63:0] k, input bit last);
        longint s = 0;
        for (int i = 0; i < 4; i++)
            s += longint'($signed(p[i*16 +: 16])) * longint'($signed(k[i*16 +: 16]));
        m_acc   = m_first ? s : m_acc + s;
        m_first = last;
        if (last) exp_q.push_back(model(m_acc));
    endfunction

    // Called just after a rising edge; returns just after the edge that took the beat
    task automatic send_beat(input logic [63:0] p, input logic [63:0] k, input bit last);
        bit fired = 1'b0;
        image_bus  = p;
        kernel_bus = k;
        image_last = last;
        image_val  = 1'b1;
        kernel_val = 1'b1;
        for (int c = 0; c < 100 && !fired; c++) begin
            @(negedge clk);
            fired = image_rdy & kernel_rdy;
            @(posedge clk);
            #1;
        end
        chk("fire_timeout", fired, 1);
        if (fired) model_beat(p, k, last);
        image_val  = 1'b0;
        kernel_val = 1'b0;
    endtask

    task automatic cfg_write(input int sh, input bit rl);
        cfg_addr  = 5'(CFG_DOT);
        cfg_data  = '0;
        cfg_data[5:0] = 6'(sh);
        cfg_data[8]   = rl;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cur_shift = sh;
        cur_relu  = rl;
    endtask

    task automatic drain();
        for (int c = 0; c < 80 && exp_q.size() != 0; c++) @(posedge clk);
        chk("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every visible result must match the head of the queue
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && result_val) begin
                if (exp_q.size() == 0) chk("extra_result", 1, 0);
                else begin
                    chk("result", longint'($signed(result_bus)), exp_q[0]);
                    if (result_rdy) void'(exp_q.pop_front());
                end
            end
            if (!rst && result_val && !result_rdy && kernel_val)
                chk("stall_image_rdy", image_rdy, 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog) result_rdy = ~result_rdy;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result_val", result_val, 0);
        chk("rst_result_bus", result_bus, 0);
        chk("rst_image_rdy", image_rdy, 0);
        chk("rst_kernel_rdy", kernel_rdy, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency: fire in cycle t, result visible in cycle t+4
        image_bus  = pack4(1, 2, 3, 4);
        kernel_bus = pack4(1, 1, 1, 1);
        image_last = 1'b1;
        image_val  = 1'b1;
        kernel_val = 1'b1;
        @(posedge clk);
        #1;
        model_beat(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 1'b1);
        image_val  = 1'b0;
        kernel_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("latency_t3", result_val, 0);
        @(posedge clk);
        #1;
        chk("latency_t4", result_val, 1);
        chk("latency_value", longint'($signed(result_bus)), 10);
        drain();

        // Three-beat negative frame, without and with ReLU
        for (int r = 0; r < 2; r++) begin
            cfg_write(0, r[0]);
            for (int b = 0; b < 3; b++)
                send_beat(pack4(2, 2, 2, 2), pack4(-1, -1, -1, -1), b == 2);
            drain();
        end

        // Shift and saturation boundaries
        cfg_write(2, 1'b0);
        send_beat(pack4(25000, 25000, 25000, 25000), pack4(1, 1, 1, 1), 1'b1);
        drain();
        cfg_write(0, 1'b0);
        send_beat(pack4(25000, 25000, 25000, 25000), pack4(2, 2, 2, 2), 1'b1);
        send_beat(pack4(25000, 25000, 25000, 25000), pack4(-2, -2, -2, -2), 1'b1);
        drain();

        // Back-to-back single-beat frames with result_rdy toggling
        cfg_write(0, 1'b0);
        tog = 1'b1;
        for (int n = 0; n < 10; n++)
            send_beat(pack4(n, n + 1, -n, 3), pack4(2, -1, 5, n), 1'b1);
        tog = 1'b0;
        @(posedge clk);
        #2;
        result_rdy = 1'b1;
        drain();

        // Kernel stream absent for five cycles mid-frame
        send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b0);
        image_bus  = pack4(9, 9, 9, 9);
        image_last = 1'b1;
        image_val  = 1'b1;
        kernel_val = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("kstall_image_rdy", image_rdy, 0);
            chk("kstall_kernel_rdy", kernel_rdy, 1);
            @(posedge clk);
            #1;
        end
        send_beat(pack4(9, 9, 9, 9), pack4(1, -2, 3, -4), 1'b1);
        drain();

        // Random multi-beat frames with a large shift
        cfg_write(16, 1'b0);
        for (int f = 0; f < 6; f++) begin
            int nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++)
                send_beat({$urandom, $urandom}, {$urandom, $urandom}, b == nb - 1);
        end
        drain();

        // Reset in the middle of a four-beat frame discards it
        cfg_write(0, 1'b1);
        send_beat(pack4(100, 100, 100, 100), pack4(7, 7, 7, 7), 1'b0);
        send_beat(pack4(100, 100, 100, 100), pack4(7, 7, 7, 7), 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        m_first   = 1'b1;
        cur_shift = 0;
        cur_relu  = 1'b0;
        chk("midrst_result_val", result_val, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_idle_val", result_val, 0);
        send_beat(pack4(1, 1, 1, 1), pack4(3, 3, 3, 3), 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/image_dot.md
# image_dot

Dot-product accumulation stage directly downstream of `image`. It joins the `image_bus` pixel-group stream with a matching kernel-weight stream and multiplies lane by lane. Products are accumulated across beats until `image_last`, then one scaled, saturated and optionally rectified result is emitted per frame. It is the first compute stage behind the image buffers and feeds the result writer.

## Interface
- `CFG_DWIDTH`, 32, configuration data width
- `CFG_AWIDTH`, 5, configuration address width
- `GROUP_NB`, 4, lanes per beat (matches `image`)
- `IMG_WIDTH`, 16, signed pixel width
- `KER_WIDTH`, 16, signed weight width
- `ACC_WIDTH`, 48, signed accumulator width
- `RES_WIDTH`, 16, signed result width
- `clk` in 1: the single clock
- `rst` in 1: synchronous, active-high reset
- `cfg_data` in CFG_DWIDTH: config write data
- `cfg_addr` in CFG_AWIDTH: config write address
- `cfg_valid` in 1: config write strobe
- `image_bus` in GROUP_NB*IMG_WIDTH: pixel lanes; lane i is at bits [i*IMG_WIDTH +: IMG_WIDTH]
- `image_last` in 1: final beat of frame
- `image_val` in 1, `image_rdy` out 1: image handshake
- `kernel_bus` in GROUP_NB*KER_WIDTH: weight lanes, same packing
- `kernel_val` in 1, `kernel_rdy` out 1: kernel handshake
- `result_bus` out RES_WIDTH: frame result
- `result_val` out 1, `result_rdy` in 1: result handshake

## Operation
- Config register `CFG_DOT` (address constant in `cfg_parameters.vh`) is written when `cfg_valid & (cfg_addr == CFG_DOT)`.
  - `cfg_data[5:0]` = `shift`.
  - `cfg_data[8]` = `relu`.
  - Both are 0 after reset.
  - A write takes effect on the next output-stage evaluation.
- Global enable: `en = ~(result_val & ~result_rdy)`. The whole pipeline freezes while the output is stalled.
- Join handshake:
  - `image_rdy = en & kernel_val`
  - `kernel_rdy = en & image_val`
  - `fire = en & image_val & kernel_val`
  - Both streams advance together on `fire`. Neither is ever consumed alone.
- S1 (on `fire`): register GROUP_NB signed products (IMG_WIDTH+KER_WIDTH bits each), `last`, and valid.
- S2: register the sign-extended adder-tree sum of the products at ACC_WIDTH, plus `last` and valid.
- S3 accumulator:
  - Holds a `first` flag; reset value is 1.
  - Valid beat with `first` = 1: `acc = sum`. With `first` = 0: `acc = acc + sum`, wrapping modulo 2^ACC_WIDTH.
  - `first` takes the value of the beat's `last`.
  - On a valid `last` beat, S3 forwards `acc_final` (the updated value) to S4.
- S4 output register:
  - `v = acc_final >>> shift` (arithmetic shift; truncation toward −inf).
  - Saturate `v` to the signed RES_WIDTH range.
  - If `relu` = 1 and the value is negative, output 0.
  - Set `result_val`.
  - Clear `result_val` on `result_val & result_rdy` when no new result arrives that cycle.
- A single-beat frame (`image_last` on every beat) yields one result per beat.
- Reset mid-frame discards all in-flight beats and the partial accumulation.

## Timing
- Reset values: `result_val` = 0, `result_bus` = 0, `image_rdy` = 0 / `kernel_rdy` = 0 (no valid present), all stage valids 0, `first` = 1, `shift` = 0, `relu` = 0.
- Latency: the `fire` of a last beat at cycle t gives `result_val` = 1 at t+4, provided no stall.
- Throughput: one beat per cycle, sustained indefinitely when `result_rdy` = 1.
- `result_bus` is stable while `result_val & ~result_rdy`.
- On the cycle `result_rdy` rises, the held result is accepted and the pipeline advances in the same cycle. There is no bubble.
- The ready outputs depend combinationally on the opposite stream's valid and on `result_rdy`. There is no combinational path from any `*_bus` input to any output.

## Structure
- Add `CFG_DOT` to the shared `cfg_parameters.vh`. Lane packing follows the `image` convention.
- One sub-module, `dot_tree`: pipelined GROUP_NB-lane signed multiply and adder tree (S1–S2) with an enable input. Accumulator, output stage and handshake stay in `image_dot`.

## Test plan
- GROUP_NB=4, pixels {1,2,3,4}, weights {1,1,1,1}, single-beat frame, shift 0 → `result_bus` = 10 at t+4.
- Three-beat frame: each beat pixels {2,2,2,2}, weights {−1,−1,−1,−1}, relu 0 → −24. Same frame with relu 1 → 0.
- Accumulated value 100000 with shift 2 → 25000. Accumulated value 200000 with shift 0 → saturates to 32767. Accumulated value −200000 with shift 0 → −32768.
- Continuous single-beat frames with `result_rdy` toggled 1010… → no result lost or duplicated, `result_bus` stable while stalled, and `image_rdy` = 0 on stalled cycles.
- `kernel_val` low for 5 cycles while `image_val` is high → no `fire`, and the image beat is held. Accumulation resumes correctly when `kernel_val` returns.
- Assert `rst` after beat 2 of a 4-beat frame → no result is emitted. The next 1-beat frame {1,1,1,1}·{3,3,3,3} gives 12, with no residue from the aborted frame.
